// File: rtl/ram_rx_pkg.sv
// Shared state encoding and default sizing for the RAM drain stage.
package ram_rx_pkg;

    typedef enum logic [4:0] {
        IDLE = 5'h01,
        WAIT = 5'h02,
        READ = 5'h04,
        CSUM = 5'h08,
        DONE = 5'h10
    } state_t;

    localparam int NUM_DEF    = 'hF00;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/ram_rx_byte_fifo.sv
// Synchronous DEPTH x DATA_W FIFO with show-ahead head; push is ignored when full, pop when empty.
// Zero-latency head read; no internal backpressure beyond the full/empty flags.
module byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_dat,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/ram_rx.sv
// Drains NUM bytes from RAM (addr 0..NUM-1) to a valid/ready byte stream, then a checksum byte.
// First txv 4 clk after start; 1 byte/clk with txr high; txr low holds txd/txv and throttles RAM reads.
module ram_rx import ram_rx_pkg::*; #(
    parameter int NUM    = NUM_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs,
    output logic              fd,
    output logic [ADDR_W-1:0] ram_rxa,
    output logic              ram_rxen,
    input  logic [DATA_W-1:0] ram_rxd,
    output logic [DATA_W-1:0] txd,
    output logic              txv,
    input  logic              txr,
    output logic [DATA_W-1:0] csum
);

    localparam int                CW    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] NUM_A = ADDR_W'(NUM);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] issue_cnt;
    logic [ADDR_W-1:0] cap_cnt;
    logic              cap_pend;
    logic [CW-1:0]     fifo_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic [CW:0]       occ_total;
    logic              issue;
    logic              load;
    logic              xfer;
    logic              data_done;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (cap_pend),
        .push_dat (ram_rxd),
        .pop      (load),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_cnt)
    );

    assign xfer      = txv && txr;
    assign data_done = (cap_cnt == NUM_A) && fifo_empty && !txv;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = WAIT;
            WAIT:    if (fs) state_nxt = READ;
            READ:    if (data_done) state_nxt = CSUM;
            CSUM:    if (xfer) state_nxt = DONE;
            DONE:    if (!fs) state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Credit check uses only registered occupancy and in-flight reads, so it
    // stays conservative: pops and captures in this cycle are not counted.
    always_comb begin
        occ_total = {1'b0, fifo_cnt} + (CW+1)'(ram_rxen) + (CW+1)'(cap_pend);
        issue     = 1'b0;
        load      = 1'b0;
        if (state == READ) begin
            issue = (issue_cnt < NUM_A) && (occ_total <= (CW+1)'(DEPTH - 1));
            load  = (!txv || txr) && !fifo_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ram_rxen  <= 1'b0;
            ram_rxa   <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            cap_pend  <= 1'b0;
            txd       <= '0;
            txv       <= 1'b0;
            csum      <= '0;
            fd        <= 1'b0;
        end else begin
            ram_rxen <= issue;
            cap_pend <= ram_rxen;
            if (issue) begin
                ram_rxa <= issue_cnt;
            end else if (state != READ) begin
                ram_rxa <= '0;
            end

            if (state == WAIT) begin
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + ADDR_W'(1);
            end

            if (state == WAIT) begin
                cap_cnt <= '0;
            end else if (cap_pend) begin
                cap_cnt <= cap_cnt + ADDR_W'(1);
            end

            // Refill on the transfer edge keeps the stream bubble-free.
            if (load) begin
                txd <= fifo_head;
                txv <= 1'b1;
            end else if (state == READ && data_done) begin
                txd <= csum;
                txv <= 1'b1;
            end else if (xfer) begin
                txv <= 1'b0;
            end

            if (state == WAIT) begin
                csum <= '0;
            end else if (state == READ && xfer) begin
                csum <= csum + txd;
            end

            fd <= (state_nxt == DONE);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(cap_pend && fifo_full));

endmodule

// File: tb/tb_ram_rx.sv
`timescale 1ns/1ps
module tb_ram_rx;

    localparam int NUM_S = 4;
    localparam int NUM_B = 'hF00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fs_s, fs_b, txr_s, txr_b;
    logic        fd_s, fd_b, ram_rxen_s, ram_rxen_b, txv_s, txv_b;
    logic [11:0] ram_rxa_s, ram_rxa_b;
    logic [7:0]  ram_rxd_s, ram_rxd_b, txd_s, txd_b, csum_s, csum_b;

    logic [7:0]  mem_s [NUM_S];
    logic [7:0]  mem_b [4096];

    always @(posedge clk) begin
        if (ram_rxen_s) ram_rxd_s <= mem_s[ram_rxa_s[1:0]];
        if (ram_rxen_b) ram_rxd_b <= mem_b[ram_rxa_b];
    end

    ram_rx #(.NUM(NUM_S), .ADDR_W(12), .DATA_W(8), .DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .fs(fs_s), .fd(fd_s),
        .ram_rxa(ram_rxa_s), .ram_rxen(ram_rxen_s), .ram_rxd(ram_rxd_s),
        .txd(txd_s), .txv(txv_s), .txr(txr_s), .csum(csum_s)
    );

    ram_rx #(.NUM(NUM_B), .ADDR_W(12), .DATA_W(8), .DEPTH(4)) u_big (
        .clk(clk), .rst(rst), .fs(fs_b), .fd(fd_b),
        .ram_rxa(ram_rxa_b), .ram_rxen(ram_rxen_b), .ram_rxd(ram_rxd_b),
        .txd(txd_b), .txv(txv_b), .txr(txr_b), .csum(csum_b)
    );

    logic [7:0] exp_s[$];
    logic [7:0] exp_b[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int xi_s = 0, rd_s = 0, last_s = 0;
    int xi_b = 0, rd_b = 0, first_b = 0;
    int mode_s = 0;
    int ph_s = 0;
    bit gap_chk_s = 1'b0, full_b = 1'b0;
    bit stall_s = 1'b0, stall_b = 1'b0, fd_prev_s = 1'b0, fd_prev_b = 1'b0;
    logic [7:0] held_s, held_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic wait_fd(input bit big, input int budget, input string name);
        int n = 0;
        while ((big ? fd_b : fd_s) !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if ((big ? fd_b : fd_s) !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: fd not seen within %0d cycles", name, budget);
        end
    endtask

    // Monitor: a transfer seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (stall_s) chk("stall_hold_s", {txv_s, txd_s}, {1'b1, held_s});
            stall_s = txv_s && !txr_s;
            held_s  = txd_s;
            if (txv_s && txr_s) begin
                if (exp_s.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_xfer_s: got %0h want no transfer", txd_s);
                end else begin
                    chk("data_s", txd_s, exp_s.pop_front());
                end
                if (gap_chk_s && xi_s > 0) chk("gap_s", cyc - last_s, (xi_s == NUM_S) ? 2 : 1);
                last_s = cyc;
                xi_s++;
            end
            if (ram_rxen_s) rd_s++;
            if (fd_s && !fd_prev_s) begin
                chk("left_s", exp_s.size(), 0);
                chk("xfers_s", xi_s, NUM_S + 1);
                chk("reads_s", rd_s, NUM_S);
                chk("csum_s", csum_s, 8'h05);
            end
            fd_prev_s = fd_s;

            if (stall_b) chk("stall_hold_b", {txv_b, txd_b}, {1'b1, held_b});
            stall_b = txv_b && !txr_b;
            held_b  = txd_b;
            if (txv_b && txr_b) begin
                if (exp_b.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_xfer_b: got %0h want no transfer", txd_b);
                end else begin
                    chk("data_b", txd_b, exp_b.pop_front());
                end
                if (full_b && xi_b == 0) first_b = cyc;
                if (full_b && xi_b == NUM_B - 1) chk("thru_b", cyc - first_b, NUM_B - 1);
                xi_b++;
            end
            if (ram_rxen_b) rd_b++;
            if (fd_b && !fd_prev_b) begin
                chk("left_b", exp_b.size(), 0);
                chk("xfers_b", xi_b, NUM_B + 1);
                chk("reads_b", rd_b, NUM_B);
                chk("csum_b", csum_b, 8'h80);
            end
            fd_prev_b = fd_b;
        end else begin
            stall_s = 1'b0;
            stall_b = 1'b0;
        end
    end

    initial begin
        txr_s = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (mode_s != 0) begin
                txr_s = (ph_s == 0);
                ph_s  = (ph_s + 1) % 3;
            end else begin
                txr_s = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_small();
        for (int i = 0; i < NUM_S; i++) exp_s.push_back(mem_s[i]);
        exp_s.push_back(8'h05);
    endtask

    task automatic push_big();
        for (int a = 0; a < NUM_B; a++) exp_b.push_back(mem_b[a]);
        exp_b.push_back(8'h80);
    endtask

    initial begin
        int lat;
        int n;
        rst   = 1'b0;
        fs_s  = 1'b0;
        fs_b  = 1'b0;
        txr_b = 1'b1;
        mem_s = '{8'h01, 8'h02, 8'h03, 8'hFF};
        for (int a = 0; a < 4096; a++) mem_b[a] = 8'(a[11:8] + a[7:0]);

        @(posedge clk); #1;
        chk("rst_fd", fd_s, 0);
        chk("rst_addr", ram_rxa_s, 0);
        chk("rst_rxen", ram_rxen_s, 0);
        chk("rst_txd", txd_s, 0);
        chk("rst_txv", txv_s, 0);
        chk("rst_csum", csum_s, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Run 1: free-flowing consumer, latency and bubble checks.
        xi_s = 0; rd_s = 0; gap_chk_s = 1'b1;
        push_small();
        fs_s = 1'b1;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (txv_s) break;
        end
        chk("first_txv_lat", lat, 4);
        wait_fd(1'b0, 100, "fd_run1");
        repeat (10) @(posedge clk); #1;
        chk("fd_hold", fd_s, 1);
        chk("no_reads_hold", rd_s, NUM_S);
        fs_s = 1'b0;
        @(posedge clk); #1;
        chk("fd_drop", fd_s, 0);
        chk("rxen_wait", ram_rxen_s, 0);

        // Run 2: identical run, checksum must restart.
        xi_s = 0; rd_s = 0;
        push_small();
        fs_s = 1'b1;
        n = 0;
        while (xi_s < 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("csum_restart", csum_s, 8'h01);
        wait_fd(1'b0, 100, "fd_run2");
        fs_s = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Run 3: stalling consumer plus an fs glitch mid-read.
        gap_chk_s = 1'b0; mode_s = 1; ph_s = 0;
        xi_s = 0; rd_s = 0;
        push_small();
        fs_s = 1'b1;
        repeat (3) @(posedge clk); #1;
        fs_s = 1'b0;
        @(posedge clk); #1;
        fs_s = 1'b1;
        chk("fd_pulse", fd_s, 0);
        wait_fd(1'b0, 200, "fd_run3");
        fs_s = 1'b0;
        mode_s = 0;
        repeat (3) @(posedge clk); #1;

        // Big: partial run interrupted by reset, then a full run.
        xi_b = 0; rd_b = 0; full_b = 1'b0;
        push_big();
        txr_b = 1'b1;
        fs_b = 1'b1;
        n = 0;
        while (xi_b < 100 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        txr_b = 1'b0;
        chk("partial_progress", xi_b, 100);
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        fs_b = 1'b0;
        @(posedge clk); #1;
        chk("midrst_txv", txv_b, 0);
        chk("midrst_rxen", ram_rxen_b, 0);
        chk("midrst_addr", ram_rxa_b, 0);
        chk("midrst_fd", fd_b, 0);
        chk("midrst_csum", csum_b, 0);
        rst = 1'b1;
        exp_b.delete();
        xi_b = 0; rd_b = 0; full_b = 1'b1;
        push_big();
        txr_b = 1'b1;
        repeat (3) @(posedge clk); #1;
        fs_b = 1'b1;
        wait_fd(1'b1, 5000, "fd_big");
        fs_b = 1'b0;
        repeat (3) @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
